// File: rtl/demux_1to8.sv
// 1-to-8 demultiplexer with enable: lane S carries I, every other lane is zero.
// OUT_REG selects a registered output (1-cycle latency) or a purely combinational one.
module demux_1to8 #(
  parameter int DW      = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     I,
  input  logic [2:0]        S,
  input  logic              E,
  output logic [8*DW-1:0]   Y
);

  logic [8*DW-1:0] y_d;

  // With E low no lane is written, so every lane stays at zero regardless of I and S.
  always_comb begin
    y_d = '0;
    if (E) begin
      y_d[int'(S)*DW +: DW] = I;
    end
  end

  generate
    if (OUT_REG) begin : g_reg
      logic [8*DW-1:0] y_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q <= '0;
        end else begin
          y_q <= y_d;
        end
      end

      assign Y = y_q;
    end else begin : g_comb
      // Clock and reset have no effect in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign Y = y_d;
    end
  endgenerate

endmodule

// File: tb/tb_demux_1to8.sv
// Bench for demux_1to8: registered DW=1 instance and combinational DW=4 instance,
// checked against a lane-shift model every negedge plus directed literal vectors.
module tb_demux_1to8;

  logic        clk;
  logic        rst_n;
  logic        i_r;
  logic [2:0]  s_r;
  logic        e_r;
  logic [7:0]  y_r;

  logic [3:0]  i_c;
  logic [2:0]  s_c;
  logic        e_c;
  logic [31:0] y_c;

  int total;
  int bad;
  bit running;

  demux_1to8 #(.DW(1), .OUT_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .I(i_r), .S(s_r), .E(e_r), .Y(y_r)
  );

  demux_1to8 #(.DW(4), .OUT_REG(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .I(i_c), .S(s_c), .E(e_c), .Y(y_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the enabled input shifted up to its lane, captured one edge later for the registered build.
  logic [7:0]  exp_r;
  logic [31:0] exp_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_r <= 8'h00;
    else        exp_r <= e_r ? (8'(i_r) << s_r) : 8'h00;
  end

  always_comb begin
    exp_c = 32'h0;
    if (e_c) exp_c = 32'(i_c) << (4 * s_c);
  end

  always @(negedge clk) begin
    if (running) begin
      total++;
      if (y_r !== exp_r) begin
        bad++;
        $display("FAIL model_reg t=%0t got=%h expected=%h", $time, y_r, exp_r);
      end
      total++;
      if (y_c !== exp_c) begin
        bad++;
        $display("FAIL model_comb t=%0t got=%h expected=%h", $time, y_c, exp_c);
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  // Returns 2 time units after a rising edge, clear of both clock edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    running = 1'b0;
    sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    rst_n = 1'b0;
    e_r = 1'b1; i_r = 1'b1; s_r = 3'd3;
    e_c = 1'b0; i_c = 4'h0; s_c = 3'd0;
    #1;
    check8("reset_async_y", y_r, 8'h00);
    running = 1'b1;

    tick();
    tick();
    check8("reset_held_y", y_r, 8'h00);
    rst_n = 1'b1;
    #1;
    check8("release_no_edge", y_r, 8'h00);
    tick();
    check8("first_edge_s3", y_r, 8'h08);

    // Select sweep, one lane per cycle
    for (int s = 0; s < 8; s++) begin
      s_r = 3'(s);
      tick();
      check8($sformatf("sweep_s%0d", s), y_r, sweep_exp[s]);
    end

    // Toggle data on lane 5; Y must hold its value until the next edge
    s_r = 3'd5;
    i_r = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check8($sformatf("toggle_%0d", k), y_r, i_r ? 8'h20 : 8'h00);
      i_r = ~i_r;
      #1;
      check8($sformatf("toggle_hold_%0d", k), y_r, i_r ? 8'h00 : 8'h20);
    end

    // Disabled: all lanes zero whatever S is
    e_r = 1'b0;
    i_r = 1'b1;
    for (int s = 0; s < 8; s++) begin
      s_r = 3'(s);
      tick();
      check8($sformatf("disabled_s%0d", s), y_r, 8'h00);
    end
    e_r = 1'b1;
    s_r = 3'd7;
    tick();
    check8("enable_s7", y_r, 8'h80);

    // Simultaneous S and I change lands together
    s_r = 3'd1;
    i_r = 1'b0;
    tick();
    check8("simul_s1_i0", y_r, 8'h00);
    s_r = 3'd4;
    i_r = 1'b1;
    tick();
    check8("simul_s4_i1", y_r, 8'h10);

    // Reset between edges while Y=40
    s_r = 3'd6;
    tick();
    check8("pre_reset_s6", y_r, 8'h40);
    #1 rst_n = 1'b0;
    #1;
    check8("midcycle_reset", y_r, 8'h00);
    tick();
    check8("reset_hold_1", y_r, 8'h00);
    tick();
    check8("reset_hold_2", y_r, 8'h00);
    rst_n = 1'b1;
    #1;
    check8("release_hold", y_r, 8'h00);
    tick();
    check8("after_release_s6", y_r, 8'h40);

    // Combinational DW=4 instance: result visible without waiting for an edge
    e_c = 1'b1; s_c = 3'd2; i_c = 4'hA;
    #1;
    check32("comb_s2_a", y_c, 32'h0000_0A00);
    s_c = 3'd7; i_c = 4'h5;
    #1;
    check32("comb_s7_5", y_c, 32'h5000_0000);
    s_c = 3'd0; i_c = 4'hF;
    #1;
    check32("comb_s0_f", y_c, 32'h0000_000F);
    e_c = 1'b0;
    #1;
    check32("comb_disabled", y_c, 32'h0000_0000);
    rst_n = 1'b0;
    e_c = 1'b1; s_c = 3'd3; i_c = 4'h9;
    #1;
    check32("comb_ignores_reset", y_c, 32'h0000_9000);
    rst_n = 1'b1;

    tick();
    tick();
    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
